traceback_unit: RTL and testbench

TRACEBACK_UNIT -- requirements
Module: traceback_unit

---
 rtl/traceback_unit.sv | 195 +++++++++++++++++++
 tb/tb_traceback_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traceback_unit.sv
// Traceback unit: walks the stored PE source pointers backwards from the
// max-score cell, emitting one alignment op per visited cell (last cell
// first) over a valid/ready handshake, then pulses done with the length
// and the last emitting cell.
module traceback_unit #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] start_row,
    input  logic [COL_W-1:0] start_col,
    output logic             mem_rd_en,
    output logic [ROW_W-1:0] mem_row,
    output logic [COL_W-1:0] mem_col,
    input  logic [1:0]       mem_source,
    input  logic             mem_zero,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] aln_len,
    output logic [ROW_W-1:0] end_row,
    output logic [COL_W-1:0] end_col
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        EMIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(ROWS + COLS);

    // Predecessor cell for a given pointer direction (diag / top / left).
    function automatic logic [ROW_W+COL_W-1:0] step_cell(
        input logic [1:0]       dir,
        input logic [ROW_W-1:0] r,
        input logic [COL_W-1:0] c
    );
        case (dir)
            2'b01:   step_cell = {r - ROW_ONE, c - COL_ONE};
            2'b10:   step_cell = {r - ROW_ONE, c};
            2'b11:   step_cell = {r, c - COL_ONE};
            default: step_cell = {r, c};
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [ROW_W-1:0] row_r, row_s, row_step_s;
    logic [COL_W-1:0] col_r, col_s, col_step_s;
    logic [LEN_W-1:0] len_r, len_s, len_inc_s;
    logic [1:0]       op_r, op_s;
    logic [ROW_W-1:0] end_row_r, end_row_s;
    logic [COL_W-1:0] end_col_r, end_col_s;
    logic [LEN_W-1:0] aln_len_r, aln_len_s;
    logic             mem_rd_en_r, op_valid_r, busy_r, done_r;
    logic [ROW_W-1:0] mem_row_r;
    logic [COL_W-1:0] mem_col_r;

    // Next-state and datapath update for the traceback walk.
    always_comb begin
        state_s    = state_r;
        row_s      = row_r;
        col_s      = col_r;
        len_s      = len_r;
        op_s       = op_r;
        end_row_s  = end_row_r;
        end_col_s  = end_col_r;
        aln_len_s  = aln_len_r;
        {row_step_s, col_step_s} = step_cell(op_r, row_r, col_r);
        // Saturate rather than wrap; the walk cannot exceed ROWS+COLS ops.
        if (len_r < LEN_MAX) begin
            len_inc_s = len_r + LEN_ONE;
        end else begin
            len_inc_s = len_r;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    row_s     = start_row;
                    col_s     = start_col;
                    len_s     = LEN_ZERO;
                    aln_len_s = LEN_ZERO;
                    end_row_s = ROW_ZERO;
                    end_col_s = COL_ZERO;
                    if ((start_row == ROW_ZERO) || (start_col == COL_ZERO)) begin
                        state_s = FINISH;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                state_s = WAIT;
            end
            WAIT: begin
                // Read data arrives one cycle after the strobe.
                if (mem_zero || (mem_source == 2'b00)) begin
                    aln_len_s = len_r;
                    state_s   = FINISH;
                end else begin
                    op_s    = mem_source;
                    state_s = EMIT;
                end
            end
            EMIT: begin
                if (op_ready) begin
                    len_s     = len_inc_s;
                    end_row_s = row_r;
                    end_col_s = col_r;
                    row_s     = row_step_s;
                    col_s     = col_step_s;
                    if ((row_step_s == ROW_ZERO) || (col_step_s == COL_ZERO)) begin
                        aln_len_s = len_inc_s;
                        state_s   = FINISH;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            row_r       <= ROW_ZERO;
            col_r       <= COL_ZERO;
            len_r       <= LEN_ZERO;
            op_r        <= 2'b00;
            end_row_r   <= ROW_ZERO;
            end_col_r   <= COL_ZERO;
            aln_len_r   <= LEN_ZERO;
            mem_rd_en_r <= 1'b0;
            mem_row_r   <= ROW_ZERO;
            mem_col_r   <= COL_ZERO;
            op_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            row_r       <= row_s;
            col_r       <= col_s;
            len_r       <= len_s;
            op_r        <= op_s;
            end_row_r   <= end_row_s;
            end_col_r   <= end_col_s;
            aln_len_r   <= aln_len_s;
            mem_rd_en_r <= (state_s == READ);
            mem_row_r   <= (state_s == READ) ? row_s : ROW_ZERO;
            mem_col_r   <= (state_s == READ) ? col_s : COL_ZERO;
            op_valid_r  <= (state_s == EMIT);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == FINISH);
        end
    end

    assign mem_rd_en = mem_rd_en_r;
    assign mem_row   = mem_row_r;
    assign mem_col   = mem_col_r;
    assign op_valid  = op_valid_r;
    assign op        = op_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aln_len   = aln_len_r;
    assign end_row   = end_row_r;
    assign end_col   = end_col_r;

endmodule

// File: tb/tb_traceback_unit.sv
// Scoreboard bench for traceback_unit: a reference walk over a bench-held
// pointer matrix predicts reads, ops and the done result; a monitor compares.
module tb_traceback_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] start_row = 4'd0;
    logic [3:0] start_col = 4'd0;
    logic       mem_rd_en;
    logic [3:0] mem_row, mem_col;
    logic [1:0] mem_source = 2'b00;
    logic       mem_zero = 1'b0;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic [1:0] op;
    logic       busy, done;
    logic [4:0] aln_len;
    logic [3:0] end_row, end_col;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit hold_low = 1'b0;

    logic [1:0] src_mem  [0:15][0:15];
    logic       zero_mem [0:15][0:15];

    int rd_q[$];     // expected read address, row*16+col
    int op_q[$];     // expected op codes in emission order
    int dn_q[$];     // expected {aln_len, end_row, end_col} packed

    traceback_unit dut (
        .clk(clk), .rst(rst), .start(start), .start_row(start_row), .start_col(start_col),
        .mem_rd_en(mem_rd_en), .mem_row(mem_row), .mem_col(mem_col),
        .mem_source(mem_source), .mem_zero(mem_zero),
        .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .busy(busy), .done(done), .aln_len(aln_len), .end_row(end_row), .end_col(end_col)
    );

    always #5 clk = ~clk;

    // One-cycle latency pointer memory.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_source <= src_mem[mem_row][mem_col];
            mem_zero   <= zero_mem[mem_row][mem_col];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input logic [1:0] s);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                src_mem[r][c]  = s;
                zero_mem[r][c] = 1'b0;
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                src_mem[r][c]  = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0) src_mem[r][c] = 2'b00;
                zero_mem[r][c] = ($urandom_range(0, 9) == 0);
            end
    endtask

    // Reference walk: follow pointers from (r,c) until stop/zero or an edge.
    task automatic model(input int r, input int c);
        int rr, cc, n, er, ec, s;
        rr = r; cc = c; n = 0; er = 0; ec = 0;
        if (r != 0 && c != 0) begin
            forever begin
                rd_q.push_back(rr * 16 + cc);
                s = int'(src_mem[rr][cc]);
                if (zero_mem[rr][cc] || s == 0) break;
                op_q.push_back(s);
                n++; er = rr; ec = cc;
                if (s == 1) begin rr--; cc--; end
                else if (s == 2) rr--;
                else cc--;
                if (rr == 0 || cc == 0) break;
            end
        end
        dn_q.push_back(n * 256 + er * 16 + ec);
    endtask

    task automatic pulse_start(input int r, input int c);
        @(posedge clk); #1;
        start = 1'b1; start_row = 4'(r); start_col = 4'(c);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        base = done_cnt;
        for (int i = 0; i < 400 && done_cnt == base; i++) @(posedge clk);
        check({name, "_done_seen"}, 32'(done_cnt != base), 32'd1);
        check({name, "_reads_left"}, 32'(rd_q.size()), 32'd0);
        check({name, "_ops_left"}, 32'(op_q.size()), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input string name, input int r, input int c);
        model(r, c);
        pulse_start(r, c);
        wait_done(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd_en"},   32'(mem_rd_en), 32'd0);
        check({name, "_mem_row"}, 32'(mem_row),   32'd0);
        check({name, "_mem_col"}, 32'(mem_col),   32'd0);
        check({name, "_valid"},   32'(op_valid),  32'd0);
        check({name, "_op"},      32'(op),        32'd0);
        check({name, "_busy"},    32'(busy),      32'd0);
        check({name, "_done"},    32'(done),      32'd0);
        check({name, "_aln_len"}, 32'(aln_len),   32'd0);
        check({name, "_end_row"}, 32'(end_row),   32'd0);
        check({name, "_end_col"}, 32'(end_col),   32'd0);
    endtask

    // Downstream ready: random, or forced low for stall tests.
    initial begin
        forever begin
            @(posedge clk); #1;
            op_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something.
    initial begin
        bit prev_stall, prev_done;
        logic [1:0] prev_op;
        int e;
        prev_stall = 1'b0; prev_done = 1'b0; prev_op = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0; prev_done = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    check("rd_busy", 32'(busy), 32'd1);
                    if (rd_q.size() == 0) check("rd_unexpected", 32'(mem_row) * 16 + 32'(mem_col), 32'hFFFF);
                    else begin
                        e = rd_q.pop_front();
                        check("rd_addr", 32'(mem_row) * 16 + 32'(mem_col), 32'(e));
                    end
                end else begin
                    check("idle_addr", 32'(mem_row) * 16 + 32'(mem_col), 32'd0);
                end
                if (prev_stall) begin
                    check("stall_valid", 32'(op_valid), 32'd1);
                    check("stall_op", 32'(op), 32'(prev_op));
                end
                if (op_valid) begin
                    check("no_read_while_valid", 32'(mem_rd_en), 32'd0);
                    if (op_ready) begin
                        if (op_q.size() == 0) check("op_unexpected", 32'(op), 32'hFFFF);
                        else begin
                            e = op_q.pop_front();
                            check("op_value", 32'(op), 32'(e));
                        end
                    end
                end
                if (prev_done) check("done_one_cycle", 32'(done), 32'd0);
                if (done) begin
                    done_cnt++;
                    check("done_busy", 32'(busy), 32'd1);
                    if (dn_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
                    else begin
                        e = dn_q.pop_front();
                        check("aln_len", 32'(aln_len), 32'(e / 256));
                        check("end_row", 32'(end_row), 32'((e / 16) % 16));
                        check("end_col", 32'(end_col), 32'(e % 16));
                    end
                end
                prev_stall = op_valid && !op_ready;
                prev_op    = op;
                prev_done  = done;
            end
        end
    end

    initial begin
        int base;
        fill(2'b00);
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Three diagonal steps down to the corner.
        fill(2'b01);
        run("diag3", 3, 3);

        // Left, top, then a zero-score cell stops the walk.
        fill(2'b00);
        src_mem[4][5] = 2'b11; src_mem[4][4] = 2'b10; zero_mem[3][4] = 1'b1; src_mem[3][4] = 2'b01;
        run("left_top_zero", 4, 5);

        // Zero start coordinate: no read, empty alignment.
        fill(2'b01);
        run("zero_col", 5, 0);
        run("zero_row", 0, 3);

        // Full-height column of top pointers.
        fill(2'b10);
        run("top8", 8, 8);

        // Downstream stall for five cycles while an op is pending.
        fill(2'b11);
        hold_low = 1'b1;
        model(3, 6);
        pulse_start(3, 6);
        for (int i = 0; i < 20 && !op_valid; i++) @(posedge clk);
        check("stall_reached", 32'(op_valid), 32'd1);
        repeat (5) @(posedge clk);
        hold_low = 1'b0;
        wait_done("stall");

        // Start while busy must be ignored.
        fill(2'b10);
        model(8, 8);
        pulse_start(8, 8);
        repeat (3) @(posedge clk);
        pulse_start(2, 3);
        wait_done("busy_start");

        // Reset during EMIT abandons the walk with no done pulse.
        fill(2'b01);
        hold_low = 1'b1;
        model(5, 5);
        pulse_start(5, 5);
        for (int i = 0; i < 20 && !op_valid; i++) @(posedge clk);
        check("rst_emit_reached", 32'(op_valid), 32'd1);
        base = done_cnt;
        @(posedge clk); #3 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        rd_q.delete(); op_q.delete(); dn_q.delete();
        hold_low = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        check("no_done_after_reset", 32'(done_cnt), 32'(base));
        run("after_reset", 3, 3);

        // Randomized matrices and start cells.
        for (int t = 0; t < 40; t++) begin
            fill_random();
            run("random", $urandom_range(0, 8), $urandom_range(0, 8));
        end

        check("final_done_q", 32'(dn_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
